// File: rtl/intersection_scheduler_pkg.sv
// Shared types and constants for the intersection phase scheduler.
//   phase_e : FSM states; the encoding is what appears on the phase output
//   sel_e   : which requester ALL_RED hands the right of way to next
//   Light*  : {green, yellow, red} lamp encodings
//   Def*    : default durations in ticks
package intersection_scheduler_pkg;

  typedef enum logic [2:0] {
    StInitRed  = 3'd0,
    StAGreen   = 3'd1,
    StAYellow  = 3'd2,
    StAllRed   = 3'd3,
    StBGreen   = 3'd4,
    StBYellow  = 3'd5,
    StPedWalk  = 3'd6,
    StPedFlash = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    SelA = 2'd0,
    SelB = 2'd1,
    SelP = 2'd2
  } sel_e;

  localparam logic [2:0] LightGreen  = 3'b100;
  localparam logic [2:0] LightYellow = 3'b010;
  localparam logic [2:0] LightRed    = 3'b001;

  localparam int unsigned DefTickDiv   = 4;
  localparam int unsigned DefMinGreen  = 5;
  localparam int unsigned DefMaxGreen  = 10;
  localparam int unsigned DefYellow    = 3;
  localparam int unsigned DefAllRed    = 2;
  localparam int unsigned DefWalk      = 6;
  localparam int unsigned DefPedFlash  = 4;

endpackage

// File: rtl/intersection_scheduler_tick_prescaler.sv
// Tick prescaler: divides the clock into ticks of TICK_DIV cycles.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   ena     : count enable; counter holds when low
//   restart : restart the count at 0 (state entry)
//   tick    : high in the last cycle of each TICK_DIV-cycle period
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      if (restart || tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Phase scheduler for a two-road intersection with a pedestrian crossing.
// Main road A rests in green; side road B and pedestrian P requests are latched
// and served round-robin, each separated by yellow and all-red clearance.
//   clk           : system clock
//   rst_n         : synchronous active-low reset (overrides ena)
//   ena           : global enable; all state holds when low
//   req           : [0] A detector (unused), [1] B detector, [2] ped button
//   a_lights      : {green, yellow, red} for road A
//   b_lights      : {green, yellow, red} for road B
//   ped_walk      : walk lamp
//   ped_dont_walk : don't-walk lamp (flashes in PED_FLASH)
//   countdown     : remaining ticks in the current timed state, 0 in A_GREEN
//   phase         : current state encoding
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DefTickDiv,
  parameter int unsigned T_MIN_GREEN = DefMinGreen,
  parameter int unsigned T_MAX_GREEN = DefMaxGreen,
  parameter int unsigned T_YELLOW    = DefYellow,
  parameter int unsigned T_ALL_RED   = DefAllRed,
  parameter int unsigned T_WALK      = DefWalk,
  parameter int unsigned T_PED_FLASH = DefPedFlash
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] req,
  output logic [2:0] a_lights,
  output logic [2:0] b_lights,
  output logic       ped_walk,
  output logic       ped_dont_walk,
  output logic [3:0] countdown,
  output logic [2:0] phase
);

  localparam logic [3:0] MinGreenLast = 4'(T_MIN_GREEN - 1);
  localparam logic [3:0] MaxGreenLast = 4'(T_MAX_GREEN - 1);
  localparam logic [3:0] YellowLast   = 4'(T_YELLOW - 1);
  localparam logic [3:0] AllRedLast   = 4'(T_ALL_RED - 1);
  localparam logic [3:0] WalkLast     = 4'(T_WALK - 1);
  localparam logic [3:0] FlashLast    = 4'(T_PED_FLASH - 1);

  phase_e     state_q, state_d;
  sel_e       next_sel_q, next_sel_d;
  logic [3:0] tmr_q, tmr_d;
  logic       pend_b_q, pend_b_d;
  logic       pend_p_q, pend_p_d;
  logic       last_p_q, last_p_d;
  logic       flash_q, flash_d;
  logic       tick;
  logic       entry;
  logic [3:0] dur;

  // A detector is informational only.
  logic unused_a_req;
  assign unused_a_req = req[0];

  // state_d only differs from state_q when ena is high, so entry implies ena.
  assign entry = (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .restart(entry),
    .tick   (tick)
  );

  // Next-state and arbitration.
  always_comb begin
    state_d    = state_q;
    next_sel_d = next_sel_q;
    if (ena) begin
      case (state_q)
        StInitRed: begin
          if (tick && tmr_q == AllRedLast) state_d = StAGreen;
        end
        StAGreen: begin
          if (tick && tmr_q >= MinGreenLast && (pend_b_q || pend_p_q)) begin
            state_d = StAYellow;
            // B wins when it is the only one pending, or when P went last.
            next_sel_d = (pend_b_q && (!pend_p_q || last_p_q)) ? SelB : SelP;
          end
        end
        StAYellow: begin
          if (tick && tmr_q == YellowLast) state_d = StAllRed;
        end
        StAllRed: begin
          if (tick && tmr_q == AllRedLast) begin
            case (next_sel_q)
              SelB:    state_d = StBGreen;
              SelP:    state_d = StPedWalk;
              default: state_d = StAGreen;
            endcase
          end
        end
        StBGreen: begin
          if (tick && (tmr_q == MaxGreenLast ||
                       (tmr_q >= MinGreenLast && !req[1]))) begin
            state_d = StBYellow;
          end
        end
        StBYellow: begin
          if (tick && tmr_q == YellowLast) state_d = StAllRed;
        end
        StPedWalk: begin
          if (tick && tmr_q == WalkLast) state_d = StPedFlash;
        end
        StPedFlash: begin
          if (tick && tmr_q == FlashLast) state_d = StAllRed;
        end
        default: state_d = StInitRed;
      endcase
      // Once B or P is being served, the following clearance returns to A.
      if (state_d == StBGreen || state_d == StPedWalk) next_sel_d = SelA;
    end
  end

  // Timer, pending latches, round-robin history and flash phase.
  always_comb begin
    tmr_d    = tmr_q;
    pend_b_d = pend_b_q;
    pend_p_d = pend_p_q;
    last_p_d = last_p_q;
    flash_d  = flash_q;
    if (ena) begin
      if (entry) begin
        tmr_d = '0;
      end else if (tick && !(state_q == StAGreen && tmr_q == 4'hF)) begin
        tmr_d = tmr_q + 4'd1;
      end

      if (req[1] && state_q != StBGreen) pend_b_d = 1'b1;
      if (req[2] && state_q != StPedWalk && state_q != StPedFlash) pend_p_d = 1'b1;
      // Clearing after setting lets a same-cycle clear win.
      if (entry && state_d == StBGreen) begin
        pend_b_d = 1'b0;
        last_p_d = 1'b0;
      end
      if (entry && state_d == StPedWalk) begin
        pend_p_d = 1'b0;
        last_p_d = 1'b1;
      end

      // Held at 1 outside PED_FLASH so the lamp starts lit on entry.
      if (state_q != StPedFlash) begin
        flash_d = 1'b1;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInitRed;
      next_sel_q <= SelA;
      tmr_q      <= '0;
      pend_b_q   <= 1'b0;
      pend_p_q   <= 1'b0;
      last_p_q   <= 1'b1;
      flash_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      next_sel_q <= next_sel_d;
      tmr_q      <= tmr_d;
      pend_b_q   <= pend_b_d;
      pend_p_q   <= pend_p_d;
      last_p_q   <= last_p_d;
      flash_q    <= flash_d;
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    a_lights      = LightRed;
    b_lights      = LightRed;
    ped_walk      = 1'b0;
    ped_dont_walk = 1'b1;
    dur           = '0;
    case (state_q)
      StInitRed:  dur = 4'(T_ALL_RED);
      StAGreen:   a_lights = LightGreen;
      StAYellow: begin
        a_lights = LightYellow;
        dur      = 4'(T_YELLOW);
      end
      StAllRed:   dur = 4'(T_ALL_RED);
      StBGreen: begin
        b_lights = LightGreen;
        dur      = 4'(T_MAX_GREEN);
      end
      StBYellow: begin
        b_lights = LightYellow;
        dur      = 4'(T_YELLOW);
      end
      StPedWalk: begin
        ped_walk      = 1'b1;
        ped_dont_walk = 1'b0;
        dur           = 4'(T_WALK);
      end
      StPedFlash: begin
        ped_dont_walk = flash_q;
        dur           = 4'(T_PED_FLASH);
      end
      default: ;
    endcase
    countdown = (state_q == StAGreen) ? 4'd0 : (dur - tmr_q);
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with default parameters.
// Cycle k is the clock period ending at the k-th enabled edge after reset
// release; outputs are sampled 1 time unit after the preceding edge.
module tb_intersection_scheduler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] req;
  logic [2:0] a_lights;
  logic [2:0] b_lights;
  logic       ped_walk;
  logic       ped_dont_walk;
  logic [3:0] countdown;
  logic [2:0] phase;

  int n_tests;
  int n_fail;
  int cyc;

  intersection_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .req          (req),
    .a_lights     (a_lights),
    .b_lights     (b_lights),
    .ped_walk     (ped_walk),
    .ped_dont_walk(ped_dont_walk),
    .countdown    (countdown),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 3'b000;
    cycle();
    cycle();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req = r;
    cycle();
    req = 3'b000;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    req     = 3'b000;

    // Reset state, then idle in A_GREEN.
    do_reset();
    check_eq("rst_phase", phase, 0);
    check_eq("rst_countdown", countdown, 2);
    check_eq("rst_a_lights", a_lights, 1);
    check_eq("rst_b_lights", b_lights, 1);
    check_eq("rst_walk", ped_walk, 0);
    check_eq("rst_dont_walk", ped_dont_walk, 1);
    check_eq("rst_last_p", dut.last_p_q, 1);
    goto_cycle(7);
    check_eq("init_red_end", phase, 0);
    goto_cycle(8);
    check_eq("a_green_entry", phase, 1);
    check_eq("a_green_lights", a_lights, 4);
    check_eq("a_green_countdown", countdown, 0);
    goto_cycle(200);
    check_eq("idle_phase", phase, 1);
    check_eq("idle_pend_b", dut.pend_b_q, 0);
    check_eq("idle_pend_p", dut.pend_p_q, 0);

    // Pedestrian pulse at cycle 10.
    do_reset();
    goto_cycle(10);
    pulse_req(3'b100);
    check_eq("ped_pend", dut.pend_p_q, 1);
    goto_cycle(27);
    check_eq("ped_a_green_end", phase, 1);
    goto_cycle(28);
    check_eq("ped_a_yellow", phase, 2);
    check_eq("ped_a_yellow_lights", a_lights, 2);
    check_eq("ped_a_yellow_cd", countdown, 3);
    goto_cycle(40);
    check_eq("ped_all_red", phase, 3);
    goto_cycle(48);
    check_eq("ped_walk_phase", phase, 6);
    check_eq("ped_walk_lamp", ped_walk, 1);
    check_eq("ped_walk_dw", ped_dont_walk, 0);
    check_eq("ped_walk_cd", countdown, 6);
    check_eq("ped_walk_pend", dut.pend_p_q, 0);
    goto_cycle(72);
    check_eq("ped_flash_phase", phase, 7);
    check_eq("ped_flash_dw0", ped_dont_walk, 1);
    check_eq("ped_flash_cd", countdown, 4);
    goto_cycle(76);
    check_eq("ped_flash_dw1", ped_dont_walk, 0);
    goto_cycle(80);
    check_eq("ped_flash_dw2", ped_dont_walk, 1);
    goto_cycle(84);
    check_eq("ped_flash_dw3", ped_dont_walk, 0);
    goto_cycle(88);
    check_eq("ped_all_red2", phase, 3);
    check_eq("ped_all_red2_dw", ped_dont_walk, 1);
    goto_cycle(96);
    check_eq("ped_back_a", phase, 1);

    // B held: B_GREEN runs to the maximum, 40 cycles.
    do_reset();
    req = 3'b010;
    goto_cycle(48);
    check_eq("bhold_b_green", phase, 4);
    check_eq("bhold_b_lights", b_lights, 4);
    check_eq("bhold_a_lights", a_lights, 1);
    check_eq("bhold_pend_b", dut.pend_b_q, 0);
    goto_cycle(87);
    check_eq("bhold_b_green_end", phase, 4);
    goto_cycle(88);
    req = 3'b000;
    check_eq("bhold_b_yellow", phase, 5);
    cycle();
    check_eq("bhold_no_relatch", dut.pend_b_q, 0);

    // B dropped two ticks into B_GREEN: 20 cycles.
    do_reset();
    req = 3'b010;
    goto_cycle(56);
    req = 3'b000;
    goto_cycle(67);
    check_eq("bdrop_b_green_end", phase, 4);
    goto_cycle(68);
    check_eq("bdrop_b_yellow", phase, 5);
    goto_cycle(100);
    check_eq("bdrop_back_a", phase, 1);

    // B and P together: B first, then P without a new press.
    do_reset();
    goto_cycle(10);
    pulse_req(3'b110);
    check_eq("both_pend_b", dut.pend_b_q, 1);
    check_eq("both_pend_p", dut.pend_p_q, 1);
    goto_cycle(48);
    check_eq("both_b_first", phase, 4);
    goto_cycle(50);
    check_eq("both_last_p0", dut.last_p_q, 0);
    goto_cycle(60);
    check_eq("both_p_kept", dut.pend_p_q, 1);
    goto_cycle(68);
    check_eq("both_b_yellow", phase, 5);
    goto_cycle(88);
    check_eq("both_a_green", phase, 1);
    goto_cycle(108);
    check_eq("both_a_yellow", phase, 2);
    goto_cycle(128);
    check_eq("both_p_walk", phase, 6);
    goto_cycle(129);
    check_eq("both_last_p1", dut.last_p_q, 1);
    // Press during PED_WALK is ignored.
    goto_cycle(130);
    pulse_req(3'b100);
    check_eq("walk_press_ignored", dut.pend_p_q, 0);
    goto_cycle(200);
    check_eq("walk_press_no_serve", phase, 1);

    // P press during B_GREEN is latched and served after B.
    do_reset();
    goto_cycle(10);
    pulse_req(3'b010);
    goto_cycle(50);
    pulse_req(3'b100);
    check_eq("bgreen_press_latched", dut.pend_p_q, 1);
    goto_cycle(88);
    check_eq("bgreen_press_a_green", phase, 1);
    goto_cycle(128);
    check_eq("bgreen_press_served", phase, 6);

    // ena low for 50 cycles in A_YELLOW.
    do_reset();
    goto_cycle(10);
    pulse_req(3'b100);
    goto_cycle(32);
    check_eq("ena_pre_cd", countdown, 2);
    ena = 1'b0;
    goto_cycle(33);
    check_eq("ena_frozen_phase0", phase, 2);
    check_eq("ena_frozen_cd0", countdown, 2);
    goto_cycle(81);
    check_eq("ena_frozen_phase1", phase, 2);
    check_eq("ena_frozen_cd1", countdown, 2);
    goto_cycle(82);
    ena = 1'b1;
    goto_cycle(89);
    check_eq("ena_yellow_end", phase, 2);
    goto_cycle(90);
    check_eq("ena_all_red", phase, 3);

    // Reset during B_GREEN, with ena low as well.
    do_reset();
    goto_cycle(10);
    pulse_req(3'b110);
    goto_cycle(50);
    check_eq("mid_rst_b_green", phase, 4);
    rst_n = 1'b0;
    ena   = 1'b0;
    cycle();
    check_eq("mid_rst_phase", phase, 0);
    check_eq("mid_rst_a", a_lights, 1);
    check_eq("mid_rst_b", b_lights, 1);
    check_eq("mid_rst_cd", countdown, 2);
    check_eq("mid_rst_pend_p", dut.pend_p_q, 0);
    rst_n = 1'b1;
    ena   = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Phase scheduler for a two-road intersection with a pedestrian crossing. It grants the single "right of way" resource to one of three requesters: main road A, side road B and the pedestrian crossing P. Main road A rests in green. B and P requests are latched and served round-robin, each service separated by yellow and all-red clearance. It drives the light outputs and a countdown digit for the 7-segment path.

## Interface
Parameters (all durations in ticks; legal range 1..15; T_MIN_GREEN ≤ T_MAX_GREEN):
- TICK_DIV, 4, clock cycles per tick (≥1)
- T_MIN_GREEN, 5, minimum green for A and for B
- T_MAX_GREEN, 10, maximum B green while B keeps requesting
- T_YELLOW, 3, yellow duration for A and for B
- T_ALL_RED, 2, clearance interval; also the reset interval
- T_WALK, 6, pedestrian walk
- T_PED_FLASH, 4, flashing don't-walk

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  global enable; when low, all registers hold
- req  in  3  [0] A detector (informational only), [1] B detector (level), [2] pedestrian button (level or pulse)
- a_lights  out  3  {green, yellow, red} for A
- b_lights  out  3  {green, yellow, red} for B
- ped_walk  out  1  walk lamp
- ped_dont_walk  out  1  don't-walk lamp
- countdown  out  4  remaining ticks in the current timed state; 0 in A_GREEN
- phase  out  3  current state encoding

## Operation
- States, with the encoding that appears on `phase`: INIT_RED=0, A_GREEN=1, A_YELLOW=2, ALL_RED=3, B_GREEN=4, B_YELLOW=5, PED_WALK=6, PED_FLASH=7.
- Timer `tmr` (4 bit):
  - Cleared on every state entry.
  - Increments on each tick.
  - A timed state of duration T exits on the tick where tmr == T-1.
- `countdown` = T − tmr in timed states.
- Pending latches `pend_b` and `pend_p`:
  - `pend_b` is set by req[1] in any state except B_GREEN.
  - `pend_p` is set by req[2] in any state except PED_WALK and PED_FLASH.
  - Each latch is cleared on the cycle its phase is entered. If a set and a clear occur in the same cycle, the clear wins.
- Round-robin arbitration:
  - Register `last_p` (reset 1) records whether P was the last requester served.
  - Only one pending: serve it.
  - Both pending: serve B if last_p = 1, otherwise serve P.
  - The winner is captured into `next_sel` on the A_GREEN→A_YELLOW transition.
- Transitions:
  - INIT_RED → A_GREEN after T_ALL_RED.
  - A_GREEN → A_YELLOW on a tick where tmr ≥ T_MIN_GREEN-1 and (pend_b | pend_p). tmr saturates at 15 in A_GREEN.
  - A_YELLOW → ALL_RED after T_YELLOW.
  - ALL_RED → B_GREEN or PED_WALK per `next_sel`, after T_ALL_RED.
  - ALL_RED → A_GREEN after T_ALL_RED when returning from B or P; `next_sel` = A.
  - B_GREEN → B_YELLOW on the tick where either:
    - tmr == T_MAX_GREEN-1, or
    - tmr ≥ T_MIN_GREEN-1 and req[1] == 0.
  - B_YELLOW → ALL_RED after T_YELLOW.
  - PED_WALK → PED_FLASH after T_WALK.
  - PED_FLASH → ALL_RED after T_PED_FLASH.
- Lights:
  - A is green/yellow only in A_GREEN/A_YELLOW and red otherwise.
  - B is green/yellow only in B_GREEN/B_YELLOW and red otherwise.
  - ped_walk = 1 only in PED_WALK.
  - ped_dont_walk = 1 in all states except PED_WALK and PED_FLASH.
  - In PED_FLASH, ped_dont_walk is 1 on entry and toggles on every tick.
- Illegal or unused state values → INIT_RED with tmr cleared.

## Timing
- All outputs are registered or decoded directly from registers; there is no combinational path from req to any output.
- Reset values:
  - phase = INIT_RED, tmr = 0, prescaler = 0, pend_b = pend_p = 0, last_p = 1, next_sel = A.
  - a_lights = b_lights = 3'b001.
  - ped_walk = 0, ped_dont_walk = 1, countdown = T_ALL_RED.
- Prescaler:
  - Restarts at 0 on every state entry.
  - tick = (prescaler == TICK_DIV-1).
  - Every timed state therefore lasts exactly T·TICK_DIV enabled cycles.
- Request latency: a req[1] or req[2] sampled at edge n is pending from cycle n+1, and is considered at the next A_GREEN tick evaluation.
- ena low: state, timers, prescaler and latches all freeze and outputs hold. Operation resumes on the cycle ena returns high.
- Reset asserted mid-phase: next edge forces the reset values regardless of ena; pending requests are lost.

## Structure
- Shared package: state localparams, light encodings ({g,y,r} = 100/010/001), default durations.
- One sub-module `tick_prescaler` (inputs clk, rst_n, ena, restart; output tick). The FSM, latches and arbiter remain in the top.

## Test plan
- Reset, no requests, defaults: INIT_RED for 8 cycles, then A_GREEN indefinitely with countdown = 0 and pend_b = pend_p = 0.
- Pedestrian pulse at cycle 10 after reset:
  - A_YELLOW at cycle 28.
  - ALL_RED at 40.
  - PED_WALK at 48.
  - PED_FLASH at 72, with ped_dont_walk toggling every 4 cycles.
  - ALL_RED at 88, A_GREEN at 96.
- req[1] held continuously: B_GREEN lasts exactly 40 cycles (T_MAX_GREEN). If instead req[1] is dropped 2 ticks into B_GREEN, B_GREEN lasts 20 cycles.
- req[1] and req[2] pulsed in the same cycle after reset:
  - B is served first.
  - P is served in the following cycle of A_GREEN→…→PED_WALK, without a new press.
  - last_p = 1 after PED_WALK.
- req[2] pressed during PED_WALK: the press is ignored (pend_p stays 0). A press during B_GREEN is latched and served after B.
- Edge cases:
  - ena low for 50 cycles mid-A_YELLOW: phase and countdown frozen, and the remaining A_YELLOW duration is unchanged afterwards.
  - rst_n low during B_GREEN: next cycle shows all red with phase = 0.
